// File: rtl/bus_share_arbiter_pkg.sv
// Shared encodings and widths for the round-robin bus share arbiter.
package bus_share_arbiter_pkg;

  localparam int REQ_N = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_share_arbiter_rr_pick.sv
// Rotating priority encoder: first set request bit starting at base, wrapping 7 -> 0.
module rr_pick
  import bus_share_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = base;
    pos   = base;
    for (int i = 0; i < REQ_N; i++) begin
      pos = base + SEL_W'(i);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin owner of the shared result bus: drives the 8:1 mux select, holds the
// grant across a ready/valid burst and forces release after MAX_HOLD beats.
module bus_share_arbiter
  import bus_share_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int NUM_REQ  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               bus_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               bus_valid,
  output logic               busy,
  output logic               timeout_evt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic             owner_req, owner_last, xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [SEL_W-1:0] sel_next, pick_base, pick_idx;
  logic             pick_found, release_own;

  assign owner_req  = req[sel_q];
  assign owner_last = last[sel_q];
  assign bus_valid  = (state_q == ST_OWN) && owner_req;
  assign xfer       = bus_valid && bus_ready;
  assign cnt_inc    = (cnt_q >= HOLD_LIM) ? cnt_q : cnt_q + CNT_W'(1);
  assign sel_next   = sel_q + SEL_W'(1);

  // While owning, the only arbitration that matters is the handoff, which
  // restarts just past the current owner; in IDLE the saved pointer is used.
  assign pick_base  = (state_q == ST_OWN) ? sel_next : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .base  (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    release_own = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = ST_OWN;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          release_own = 1'b1;
        end else if (xfer) begin
          if (owner_last) begin
            release_own = 1'b1;
          end else if (cnt_inc == HOLD_LIM) begin
            release_own = 1'b1;
            tmo_d       = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        if (release_own) begin
          ptr_d = sel_next;
          cnt_d = '0;
          if (pick_found) begin
            sel_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mux_sel     = sel_q;
  assign busy        = (state_q == ST_OWN);
  assign grant       = busy ? (NUM_REQ'(1) << sel_q) : '0;
  assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed-vector bench for bus_share_arbiter with hand-computed expectations.
module tb_bus_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] last;
  logic       bus_ready;
  logic [7:0] grant;
  logic [2:0] mux_sel;
  logic       bus_valid;
  logic       busy;
  logic       timeout_evt;

  int checks = 0;
  int errors = 0;

  bus_share_arbiter #(.MAX_HOLD(4), .NUM_REQ(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .bus_ready   (bus_ready),
    .grant       (grant),
    .mux_sel     (mux_sel),
    .bus_valid   (bus_valid),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; last = '0; bus_ready = 1'b0;
    step();
    checks++;
    if ({grant, mux_sel, bus_valid, busy, timeout_evt} !== 14'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%h sel=%0d valid=%b busy=%b tmo=%b want all 0",
               grant, mux_sel, bus_valid, busy, timeout_evt);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_beat();
    test_reset();
    req = 8'h04; last = 8'h04; bus_ready = 1'b1;
    step();
    checks++;
    if (grant !== 8'h04 || mux_sel !== 3'd2 || bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got grant=%h sel=%0d valid=%b want 04/2/1", grant, mux_sel, bus_valid);
    end
    step();
    checks++;
    if (timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL single_last_no_tmo got %b want 0", timeout_evt);
    end
    req = 8'h00; last = 8'h00;
    step();
    checks++;
    if (busy !== 1'b0 || grant !== 8'h00 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b grant=%h valid=%b want 0/00/0", busy, grant, bus_valid);
    end
    // ptr is now 3, so requester 0 beats requester 2.
    req = 8'h05;
    step();
    checks++;
    if (mux_sel !== 3'd0 || grant !== 8'h01) begin
      errors++;
      $display("FAIL single_ptr3 got sel=%0d grant=%h want 0/01", mux_sel, grant);
    end
  endtask

  task automatic test_rotate_all();
    test_reset();
    req = 8'hFF; last = 8'hFF; bus_ready = 1'b1;
    step();
    checks++;
    if (mux_sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rotate_first got sel=%0d busy=%b want 0/1", mux_sel, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (mux_sel !== 3'(k % 8) || busy !== 1'b1 || grant !== (8'h01 << (k % 8))) begin
        errors++;
        $display("FAIL rotate_%0d got sel=%0d busy=%b grant=%h want sel=%0d busy=1", k, mux_sel, busy, grant, k % 8);
      end
    end
  endtask

  task automatic test_timeout();
    test_reset();
    req = 8'h20; last = 8'h00; bus_ready = 1'b1;
    step();
    checks++;
    if (grant !== 8'h20) begin
      errors++;
      $display("FAIL tmo_grant got %h want 20", grant);
    end
    for (int b = 1; b <= 5; b++) begin
      step();
      checks++;
      if (timeout_evt !== (b == 4) || grant !== 8'h20) begin
        errors++;
        $display("FAIL tmo_beat%0d got tmo=%b grant=%h want tmo=%b grant=20", b, timeout_evt, grant, (b == 4));
      end
    end
  endtask

  task automatic test_stall_abandon();
    test_reset();
    req = 8'h48; last = 8'h00; bus_ready = 1'b0;
    step();
    checks++;
    if (grant !== 8'h08) begin
      errors++;
      $display("FAIL stall_grant got %h want 08", grant);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (grant !== 8'h08 || timeout_evt !== 1'b0 || bus_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_cyc%0d got grant=%h tmo=%b valid=%b want 08/0/1", c, grant, timeout_evt, bus_valid);
      end
    end
    // Three beats must not hit the limit if the stall left the count at zero.
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (grant !== 8'h08 || timeout_evt !== 1'b0) begin
        errors++;
        $display("FAIL stall_beat%0d got grant=%h tmo=%b want 08/0", c, grant, timeout_evt);
      end
    end
    req = 8'h40;
    step();
    checks++;
    if (grant !== 8'h40 || mux_sel !== 3'd6 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL abandon_handoff got grant=%h sel=%0d tmo=%b want 40/6/0", grant, mux_sel, timeout_evt);
    end
  endtask

  task automatic test_reset_mid_burst();
    test_reset();
    req = 8'h06; last = 8'h00; bus_ready = 1'b1;
    step();
    checks++;
    if (grant !== 8'h02) begin
      errors++;
      $display("FAIL midrst_grant got %h want 02", grant);
    end
    step();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00 || mux_sel !== 3'd0 || bus_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got grant=%h sel=%0d valid=%b busy=%b want 00/0/0/0", grant, mux_sel, bus_valid, busy);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (grant !== 8'h02 || mux_sel !== 3'd1) begin
      errors++;
      $display("FAIL midrst_restart got grant=%h sel=%0d want 02/1", grant, mux_sel);
    end
  endtask

  task automatic test_wrap_pair();
    test_reset();
    req = 8'h80; last = 8'h80; bus_ready = 1'b1;
    step();
    checks++;
    if (mux_sel !== 3'd7) begin
      errors++;
      $display("FAIL wrap_own7 got %0d want 7", mux_sel);
    end
    req = 8'h81; last = 8'h81;
    step();
    checks++;
    if (mux_sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_to0 got sel=%0d busy=%b want 0/1", mux_sel, busy);
    end
    step();
    checks++;
    if (mux_sel !== 3'd7 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL wrap_back7 got sel=%0d tmo=%b want 7/0", mux_sel, timeout_evt);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_rotate_all();
    test_timeout();
    test_stall_abandon();
    test_reset_mid_burst();
    test_wrap_pair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
